// File: rtl/alu_pkg.sv
// Shared opcode encoding and default datapath width for the ALU and its control unit.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_MUL   = 4'h3,
        OP_MOD   = 4'h4,
        OP_PASSB = 4'h6,
        OP_INAC  = 4'h7,
        OP_DECAC = 4'h8,
        OP_RESET = 4'h9
    } alu_op_e;

endpackage

// File: rtl/alu_32bit_if.sv
// Operand/opcode request bundle and registered result bundle of the ALU.
interface alu_32bit_if #(
    parameter int unsigned WIDTH = alu_pkg::DEFAULT_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             en;
    logic [WIDTH-1:0] c;
    logic             z;

    modport master (output a, b, op, en, input  c, z);
    modport slave  (input  a, b, op, en, output c, z);
    modport core   (input  a, b, op);
endinterface

// File: rtl/alu_32bit_core.sv
// Combinational ALU datapath; o_valid is low for opcodes that must leave the result registers untouched.
module alu_32bit_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    alu_32bit_if.core        bus,
    output logic [WIDTH-1:0] o_result,
    output logic             o_valid
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_comb begin
        o_result = '0;
        o_valid  = 1'b1;
        case (bus.op)
            OP_ADD:   o_result = bus.a + bus.b;
            OP_SUB:   o_result = bus.a - bus.b;
            OP_MUL:   o_result = bus.a * bus.b;
            // Divide-by-zero passes A through rather than producing an undefined value
            OP_MOD:   o_result = (bus.b == '0) ? bus.a : (bus.a % bus.b);
            OP_PASSB: o_result = bus.b;
            OP_INAC:  o_result = bus.a + ONE;
            OP_DECAC: o_result = bus.a - ONE;
            OP_RESET: o_result = '0;
            default:  o_valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_32bit.sv
// Registered 32-bit ALU: C_bus/Z_flag load on each enabled edge with a recognised opcode, otherwise hold.
module alu_32bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A_bus,
    input  logic [WIDTH-1:0] B_bus,
    input  logic [3:0]       Control,
    input  logic             enable,
    output logic [WIDTH-1:0] C_bus,
    output logic             Z_flag
);

    alu_32bit_if #(.WIDTH(WIDTH)) w_bus ();

    logic [WIDTH-1:0] w_result;
    logic             w_valid;
    logic [WIDTH-1:0] r_c;
    logic             r_z;

    assign w_bus.a  = A_bus;
    assign w_bus.b  = B_bus;
    assign w_bus.op = Control;
    assign w_bus.en = enable;
    assign w_bus.c  = r_c;
    assign w_bus.z  = r_z;

    alu_32bit_core #(.WIDTH(WIDTH)) u_core (
        .bus      (w_bus),
        .o_result (w_result),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c <= '0;
            r_z <= 1'b1;
        end else if (w_bus.en && w_valid) begin
            r_c <= w_result;
            r_z <= (w_result == '0);
        end
    end

    assign C_bus  = w_bus.c;
    assign Z_flag = w_bus.z;

endmodule

// File: tb/tb_alu_32bit.sv
// Scoreboard bench for alu_32bit: directed vectors plus randomised traffic against a reference model.
module tb_alu_32bit;

    typedef struct {
        logic [31:0] c;
        logic        z;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    logic [31:0] m_c;
    logic        m_z;

    always #5 clk = ~clk;

    alu_32bit_if #(.WIDTH(32)) tb_if ();

    alu_32bit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A_bus   (tb_if.a),
        .B_bus   (tb_if.b),
        .Control (tb_if.op),
        .enable  (tb_if.en),
        .C_bus   (tb_if.c),
        .Z_flag  (tb_if.z)
    );

    function automatic logic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r);
        r = 32'h0;
        case (op)
            4'h1: r = a + b;
            4'h2: r = a - b;
            4'h3: r = a * b;
            4'h4: r = (b == 32'h0) ? a : a % b;
            4'h6: r = b;
            4'h7: r = a + 32'h1;
            4'h8: r = a - 32'h1;
            4'h9: r = 32'h0;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst_n    = r;
        tb_if.en = e;
        tb_if.op = op;
        tb_if.a  = a;
        tb_if.b  = b;
    endtask

    task automatic expect_out(input logic [31:0] c, input logic z, input string name);
        exp_t e;
        e.c  = c;
        e.z  = z;
        e.name = name;
        q.push_back(e);
        m_c = c;
        m_z = z;
    endtask

    task automatic vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic z, input string name);
        drive(1'b1, 1'b1, op, a, b);
        expect_out(c, z, name);
    endtask

    // Monitor: every edge that has a pending expectation is checked one time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (tb_if.c !== e.c || tb_if.z !== e.z) begin
                    errors++;
                    $display("FAIL %s: got C=%h Z=%b, expected C=%h Z=%b", e.name, tb_if.c, tb_if.z, e.c, e.z);
                end
                checks++;
                if (tb_if.z !== (tb_if.c == 32'h0)) begin
                    errors++;
                    $display("FAIL zflag_consistency(%s): got Z=%b with C=%h", e.name, tb_if.z, tb_if.c);
                end
            end
        end
    end

    initial begin
        logic [3:0]  ops [8];
        logic [31:0] a, b, r;
        logic        en, ok;
        int unsigned waited;

        ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9};
        rst_n = 1'b0;
        tb_if.en = 1'b0;
        tb_if.op = 4'h0;
        tb_if.a  = 32'h0;
        tb_if.b  = 32'h0;

        drive(1'b0, 1'b1, 4'h1, 32'h11, 32'h22);
        expect_out(32'h0, 1'b1, "reset_edge1");
        drive(1'b0, 1'b1, 4'h1, 32'h11, 32'h22);
        expect_out(32'h0, 1'b1, "reset_edge2");

        vec(4'h1, 32'h000000AA, 32'h00000055, 32'h000000FF, 1'b0, "add");
        vec(4'h2, 32'hABCDEF01, 32'h01234567, 32'hAAAAA99A, 1'b0, "sub");
        vec(4'h3, 32'hABCDEF01, 32'h01234567, 32'h4F696E67, 1'b0, "mul");
        vec(4'h4, 32'hABCDEF01, 32'h01234567, 32'h012344A7, 1'b0, "mod");
        vec(4'h6, 32'hABCDEF01, 32'h01234567, 32'h01234567, 1'b0, "passb");
        vec(4'h8, 32'hABCDEF01, 32'h01234567, 32'hABCDEF00, 1'b0, "decac");
        vec(4'h7, 32'hABCDEF01, 32'h01234567, 32'hABCDEF02, 1'b0, "inac");
        vec(4'h9, 32'hABCDEF01, 32'h01234567, 32'h00000000, 1'b1, "reset_op");
        vec(4'h7, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, "inac_wrap");
        vec(4'h8, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, "decac_wrap");
        vec(4'h2, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, "sub_zero");
        vec(4'h4, 32'h00000005, 32'h00000000, 32'h00000005, 1'b0, "mod_by_zero");
        vec(4'h6, 32'h0, 32'h00001234, 32'h00001234, 1'b0, "load_1234");

        drive(1'b1, 1'b0, 4'h1, 32'h0F0F0F0F, 32'h01010101);
        expect_out(32'h00001234, 1'b0, "hold_enable_low");
        vec(4'h5, 32'h77777777, 32'h88888888, 32'h00001234, 1'b0, "hold_op_0101");
        vec(4'hF, 32'h77777777, 32'h88888888, 32'h00001234, 1'b0, "hold_op_1111");
        vec(4'h0, 32'h77777777, 32'h88888888, 32'h00001234, 1'b0, "hold_op_0000");

        for (int unsigned i = 0; i < 1000; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 16)) : $urandom;
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFFFFFF;
            en = 1'($urandom_range(0, 1));
            ok = ref_alu(ops[$urandom_range(0, 7)], a, b, r);
            drive(1'b1, en, tb_if.op, a, b);
            tb_if.op = ops[$urandom_range(0, 7)];
            ok = ref_alu(tb_if.op, a, b, r);
            if (en && ok) expect_out(r, (r == 32'h0), "random");
            else          expect_out(m_c, m_z, "random_hold");
        end

        drive(1'b0, 1'b0, 4'h1, 32'h1, 32'h1);
        expect_out(32'h0, 1'b1, "reset_over_disable");
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
